dll_tx_arbiter: RTL and testbench

- Transmit-side scheduler of the DLL. Shares the single 32-byte-per-cycle path to PIPE between two sources:
  - the TLP stream from the packetizer/retry path;
  - DLLP requesters (Ack/Nak and InitFC/UpdateFC).
- Gates traffic by the DLCMSM state.
- Never splits a TLP. Bounds DLLP latency behind back-to-back TLPs.

---
 rtl/dll_pkg.sv | 21 ++
 rtl/dll_tx_arbiter_if.sv | 41 ++++
 rtl/dll_dllp_beat_packer.sv | 20 ++
 rtl/dll_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_dll_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dll_pkg.sv
// Shared DLL transmit definitions: link-state encoding, DLLP lane layout and
// the arbiter's packet-boundary state.
package dll_pkg;

    typedef enum logic [1:0] {
        INACTIVE = 2'd0,
        INIT1    = 2'd1,
        INIT2    = 2'd2,
        ACTIVE   = 2'd3
    } dlcm_state_t;

    localparam int unsigned DLLP_WIDTH    = 64;
    localparam int unsigned ACKN_LANE_LSB = 0;
    localparam int unsigned FC_LANE_LSB   = 64;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_TLP  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dll_tx_arbiter_if.sv
// Bundle of the DLL transmit arbiter's request, TLP stream and PIPE signals.
// master drives the sources and the link state; slave is the arbiter side.
interface dll_tx_arbiter_if #(
    parameter int unsigned PIPE_DATA_WIDTH = 256
) ();
    import dll_pkg::*;

    logic [1:0]                 dlcm_state_i;
    logic                       ackn_req_i;
    logic [DLLP_WIDTH-1:0]      ackn_data_i;
    logic                       ackn_gnt_o;
    logic                       fc_req_i;
    logic [DLLP_WIDTH-1:0]      fc_data_i;
    logic                       fc_gnt_o;
    logic                       tlp_valid_i;
    logic                       tlp_sop_i;
    logic                       tlp_eop_i;
    logic [PIPE_DATA_WIDTH-1:0] tlp_data_i;
    logic                       tlp_ready_o;
    logic                       tlp_abort_o;
    logic [PIPE_DATA_WIDTH-1:0] pipe_data_o;
    logic                       pipe_valid_o;
    logic                       pipe_is_dllp_o;

    modport master (
        output dlcm_state_i,
        output ackn_req_i, ackn_data_i, fc_req_i, fc_data_i,
        output tlp_valid_i, tlp_sop_i, tlp_eop_i, tlp_data_i,
        input  ackn_gnt_o, fc_gnt_o, tlp_ready_o, tlp_abort_o,
        input  pipe_data_o, pipe_valid_o, pipe_is_dllp_o
    );

    modport slave (
        input  dlcm_state_i,
        input  ackn_req_i, ackn_data_i, fc_req_i, fc_data_i,
        input  tlp_valid_i, tlp_sop_i, tlp_eop_i, tlp_data_i,
        output ackn_gnt_o, fc_gnt_o, tlp_ready_o, tlp_abort_o,
        output pipe_data_o, pipe_valid_o, pipe_is_dllp_o
    );

endinterface

// File: rtl/dll_dllp_beat_packer.sv
// Merges the Ack/Nak and FC DLLPs into one PIPE beat; an absent lane reads 0.
module dll_dllp_beat_packer
    import dll_pkg::*;
#(
    parameter int unsigned PIPE_DATA_WIDTH = 256
) (
    input  logic                       ackn_en_i,
    input  logic [DLLP_WIDTH-1:0]      ackn_data_i,
    input  logic                       fc_en_i,
    input  logic [DLLP_WIDTH-1:0]      fc_data_i,
    output logic [PIPE_DATA_WIDTH-1:0] beat_o
);

    always_comb begin
        beat_o = '0;
        if (ackn_en_i) beat_o[ACKN_LANE_LSB +: DLLP_WIDTH] = ackn_data_i;
        if (fc_en_i)   beat_o[FC_LANE_LSB +: DLLP_WIDTH]   = fc_data_i;
    end

endmodule

// File: rtl/dll_tx_arbiter.sv
// DLL transmit scheduler: shares the PIPE beat path between whole TLPs and
// DLLPs, gated by the link state, with bounded DLLP latency behind TLP bursts.
module dll_tx_arbiter
    import dll_pkg::*;
#(
    parameter int unsigned PIPE_DATA_WIDTH = 256,
    parameter int unsigned MAX_TLP_BURST   = 4
) (
    input logic             sclk,
    input logic             rst,
    dll_tx_arbiter_if.slave bus
);

    localparam int unsigned BurstCntW = $clog2(MAX_TLP_BURST + 1);
    localparam logic [BurstCntW-1:0] BurstLimit = BurstCntW'(MAX_TLP_BURST);

    dlcm_state_t                link;
    arb_state_t                 state_q, state_d;
    logic [BurstCntW-1:0]       burst_cnt_q, burst_cnt_d;
    logic                       dllp_pend;
    logic                       ackn_take, fc_take, dllp_sent;
    logic                       tlp_ready, tlp_accept, tlp_abort;
    logic [PIPE_DATA_WIDTH-1:0] dllp_beat;
    logic [PIPE_DATA_WIDTH-1:0] pipe_data_d, pipe_data_q;
    logic                       pipe_valid_d, pipe_valid_q;
    logic                       pipe_is_dllp_d, pipe_is_dllp_q;

    assign link      = dlcm_state_t'(bus.dlcm_state_i);
    assign dllp_pend = bus.ackn_req_i | bus.fc_req_i;

    // Combinational outputs are forced low while reset is held.
    always_comb begin
        ackn_take  = 1'b0;
        fc_take    = 1'b0;
        tlp_ready  = 1'b0;
        tlp_abort  = 1'b0;
        tlp_accept = 1'b0;
        state_d    = state_q;
        if (!rst) begin
            if (link == ACTIVE) begin
                if (state_q == S_TLP) begin
                    tlp_ready = 1'b1;
                end else if (dllp_pend && (!bus.tlp_valid_i || burst_cnt_q >= BurstLimit)) begin
                    ackn_take = bus.ackn_req_i;
                    fc_take   = bus.fc_req_i;
                end else begin
                    tlp_ready = 1'b1;
                end
            end else begin
                fc_take = (link == INIT1 || link == INIT2) && bus.fc_req_i;
                if (state_q == S_TLP) begin
                    tlp_abort = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            tlp_accept = bus.tlp_valid_i & tlp_ready;
            if (tlp_accept) state_d = bus.tlp_eop_i ? S_IDLE : S_TLP;
        end
    end

    assign dllp_sent = ackn_take | fc_take;

    dll_dllp_beat_packer #(
        .PIPE_DATA_WIDTH(PIPE_DATA_WIDTH)
    ) u_packer (
        .ackn_en_i  (ackn_take),
        .ackn_data_i(bus.ackn_data_i),
        .fc_en_i    (fc_take),
        .fc_data_i  (bus.fc_data_i),
        .beat_o     (dllp_beat)
    );

    // burst_cnt counts TLPs that overtook a still-pending DLLP.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!dllp_pend || dllp_sent) begin
            burst_cnt_d = '0;
        end else if (tlp_accept && bus.tlp_eop_i && burst_cnt_q != '1) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_comb begin
        pipe_data_d    = '0;
        pipe_valid_d   = 1'b0;
        pipe_is_dllp_d = 1'b0;
        if (dllp_sent) begin
            pipe_data_d    = dllp_beat;
            pipe_valid_d   = 1'b1;
            pipe_is_dllp_d = 1'b1;
        end else if (tlp_accept) begin
            pipe_data_d  = bus.tlp_data_i;
            pipe_valid_d = 1'b1;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            burst_cnt_q    <= '0;
            pipe_data_q    <= '0;
            pipe_valid_q   <= 1'b0;
            pipe_is_dllp_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            burst_cnt_q    <= burst_cnt_d;
            pipe_data_q    <= pipe_data_d;
            pipe_valid_q   <= pipe_valid_d;
            pipe_is_dllp_q <= pipe_is_dllp_d;
        end
    end

    assign bus.ackn_gnt_o     = ackn_take;
    assign bus.fc_gnt_o       = fc_take;
    assign bus.tlp_ready_o    = tlp_ready;
    assign bus.tlp_abort_o    = tlp_abort;
    assign bus.pipe_data_o    = pipe_data_q;
    assign bus.pipe_valid_o   = pipe_valid_q;
    assign bus.pipe_is_dllp_o = pipe_is_dllp_q;

    // An accepted beat opens a TLP exactly when the arbiter sits at a boundary.
    sop_at_boundary: assert property (@(posedge sclk) disable iff (rst)
        tlp_accept |-> (bus.tlp_sop_i == (state_q == S_IDLE)));

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// Directed plus randomized bench for dll_tx_arbiter against a packet-level
// reference model of the scheduling rules.
module tb_dll_tx_arbiter;
    import dll_pkg::*;

    localparam int unsigned W        = 256;
    localparam int unsigned MaxBurst = 4;

    typedef struct {
        logic [W-1:0] data;
        bit           sop;
        bit           eop;
    } beat_t;

    logic sclk = 1'b0;
    logic rst;
    always #5 sclk = ~sclk;

    dll_tx_arbiter_if #(.PIPE_DATA_WIDTH(W)) bus ();

    dll_tx_arbiter #(
        .PIPE_DATA_WIDTH(W),
        .MAX_TLP_BURST  (MaxBurst)
    ) dut (
        .sclk(sclk),
        .rst (rst),
        .bus (bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Source-side state: TLP beat queue and the two DLLP requesters.
    beat_t       tq[$];
    bit          gap;
    logic [1:0]  link;
    bit          a_pend, f_pend;
    logic [63:0] a_data, f_data;

    // Model state: inside a packet, and TLPs completed while a DLLP waited.
    bit m_in_pkt;
    int m_passed;

    int obs_tlp_before_dllp;
    bit obs_dllp_seen;
    int obs_aborts;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic add_tlp(input int len);
        for (int i = 0; i < len; i++) tq.push_back('{rand_beat(), i == 0, i == len - 1});
    endtask

    // Drop the unsent remainder of the packet currently at the queue head.
    task automatic flush_pkt();
        bit done = 1'b0;
        while (tq.size() > 0 && !done) begin
            done = tq[0].eop;
            void'(tq.pop_front());
        end
    endtask

    task automatic drive();
        bus.dlcm_state_i = link;
        bus.ackn_req_i   = a_pend;
        bus.ackn_data_i  = a_data;
        bus.fc_req_i     = f_pend;
        bus.fc_data_i    = f_data;
        if (tq.size() > 0 && !gap) begin
            bus.tlp_valid_i = 1'b1;
            bus.tlp_sop_i   = tq[0].sop;
            bus.tlp_eop_i   = tq[0].eop;
            bus.tlp_data_i  = tq[0].data;
        end else begin
            bus.tlp_valid_i = 1'b0;
            bus.tlp_sop_i   = 1'b0;
            bus.tlp_eop_i   = 1'b0;
            bus.tlp_data_i  = '0;
        end
    endtask

    // One clock: drive, check grants mid-cycle, check the registered beat after the edge.
    task automatic cycle();
        bit v, pend, turn, ga, gf, er, eab, acc, eop;
        logic [W-1:0] e_data;
        bit e_valid, e_dllp;
        drive();
        @(negedge sclk);
        v    = tq.size() > 0 && !gap;
        eop  = v && tq[0].eop;
        pend = a_pend || f_pend;
        ga   = 1'b0;
        gf   = 1'b0;
        er   = 1'b0;
        eab  = m_in_pkt && link != ACTIVE;
        if (link == ACTIVE) begin
            if (m_in_pkt) begin
                er = 1'b1;
            end else begin
                turn = pend && (!v || m_passed >= MaxBurst);
                ga   = turn && a_pend;
                gf   = turn && f_pend;
                er   = !turn;
            end
        end else if (link != INACTIVE) begin
            gf = f_pend;
        end
        acc = v && er;
        check("ackn_gnt", bus.ackn_gnt_o, ga);
        check("fc_gnt", bus.fc_gnt_o, gf);
        check("tlp_abort", bus.tlp_abort_o, eab);
        if (v || link != ACTIVE || m_in_pkt) check("tlp_ready", bus.tlp_ready_o, er);
        if (bus.tlp_abort_o) obs_aborts++;

        e_data  = '0;
        e_valid = 1'b0;
        e_dllp  = 1'b0;
        if (ga || gf) begin
            if (ga) e_data[63:0]   = a_data;
            if (gf) e_data[127:64] = f_data;
            e_valid = 1'b1;
            e_dllp  = 1'b1;
        end else if (acc) begin
            e_data  = tq[0].data;
            e_valid = 1'b1;
        end

        @(posedge sclk);
        #1;
        check("pipe_valid", bus.pipe_valid_o, e_valid);
        check("pipe_is_dllp", bus.pipe_is_dllp_o, e_dllp);
        check("pipe_data", bus.pipe_data_o, e_data);
        if (bus.pipe_valid_o && !bus.pipe_is_dllp_o && !obs_dllp_seen) obs_tlp_before_dllp++;
        if (bus.pipe_valid_o && bus.pipe_is_dllp_o) obs_dllp_seen = 1'b1;

        if (!pend || ga || gf) m_passed = 0;
        else if (acc && eop)   m_passed++;
        if (eab) begin
            m_in_pkt = 1'b0;
            flush_pkt();
        end else if (acc) begin
            m_in_pkt = !eop;
            void'(tq.pop_front());
        end
        if (ga) a_pend = 1'b0;
        if (gf) f_pend = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pipe_data"}, bus.pipe_data_o, '0);
        check({tag, "_pipe_valid"}, bus.pipe_valid_o, 1'b0);
        check({tag, "_pipe_is_dllp"}, bus.pipe_is_dllp_o, 1'b0);
        check({tag, "_ackn_gnt"}, bus.ackn_gnt_o, 1'b0);
        check({tag, "_fc_gnt"}, bus.fc_gnt_o, 1'b0);
        check({tag, "_tlp_ready"}, bus.tlp_ready_o, 1'b0);
        check({tag, "_tlp_abort"}, bus.tlp_abort_o, 1'b0);
    endtask

    // Assert reset mid-cycle, release just after the following edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        @(posedge sclk);
        #1;
        rst = 1'b0;
        if (m_in_pkt) flush_pkt();
        m_in_pkt = 1'b0;
        m_passed = 0;
    endtask

    initial begin
        gap    = 1'b0;
        link   = INACTIVE;
        a_pend = 1'b0;
        f_pend = 1'b0;
        a_data = '0;
        f_data = '0;
        m_in_pkt = 1'b0;
        m_passed = 0;
        obs_tlp_before_dllp = 0;
        obs_dllp_seen = 1'b0;
        obs_aborts = 0;
        drive();
        do_reset("por");

        // Reset lands while beat 2 of a 3-beat TLP is presented.
        link = ACTIVE;
        add_tlp(3);
        cycle();
        drive();
        #2;
        do_reset("mid_tlp_rst");
        add_tlp(2);
        repeat (3) cycle();

        // INIT1: only FC is granted; ackn and TLP are held.
        link   = INIT1;
        a_pend = 1'b1;
        a_data = {$urandom(), $urandom()};
        f_pend = 1'b1;
        f_data = {$urandom(), $urandom()};
        add_tlp(1);
        repeat (3) cycle();
        link = ACTIVE;
        repeat (4) cycle();

        // Both DLLPs packed into one beat.
        a_pend = 1'b1;
        a_data = {$urandom(), $urandom()};
        f_pend = 1'b1;
        f_data = {$urandom(), $urandom()};
        repeat (2) cycle();

        // Back-to-back 2-beat TLPs hold off a pending ackn for MaxBurst packets.
        obs_tlp_before_dllp = 0;
        obs_dllp_seen = 1'b0;
        repeat (6) add_tlp(2);
        a_pend = 1'b1;
        a_data = {$urandom(), $urandom()};
        repeat (16) cycle();
        check("burst_tlp_beats_before_dllp", obs_tlp_before_dllp, 2 * MaxBurst);
        check("burst_dllp_seen", obs_dllp_seen, 1'b1);

        // Valid gap mid-TLP, ackn raised during the gap.
        add_tlp(3);
        cycle();
        gap    = 1'b1;
        a_pend = 1'b1;
        a_data = {$urandom(), $urandom()};
        cycle();
        gap = 1'b0;
        repeat (4) cycle();

        // Link drops to INIT2 on beat 2 of a 4-beat TLP.
        obs_aborts = 0;
        add_tlp(4);
        cycle();
        link = INIT2;
        repeat (3) cycle();
        check("abort_pulse_count", obs_aborts, 1);
        link = ACTIVE;
        add_tlp(1);
        repeat (3) cycle();

        // Randomized traffic, link flaps, gaps and DLLP requests.
        for (int n = 0; n < 600; n++) begin
            if (tq.size() < 4 && $urandom_range(0, 2) == 0) add_tlp(int'($urandom_range(1, 4)));
            if (!a_pend && $urandom_range(0, 7) == 0) begin
                a_pend = 1'b1;
                a_data = {$urandom(), $urandom()};
            end
            if (!f_pend && $urandom_range(0, 9) == 0) begin
                f_pend = 1'b1;
                f_data = {$urandom(), $urandom()};
            end
            gap = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 49) == 0)                    link = 2'($urandom_range(0, 3));
            else if (link != ACTIVE && $urandom_range(0, 5) == 0) link = ACTIVE;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
